// File: rtl/winograd_pkg.sv
// Shared constants and state type for the Winograd F(2x2,3x3) filter transform.
package winograd_pkg;

  localparam int WG_TILE  = 4;  // transformed tile edge (U is WG_TILE x WG_TILE)
  localparam int WG_KSIZE = 3;  // spatial filter edge
  localparam int WG_OUT   = 2;  // output tile edge of the matching conv kernel

  typedef enum logic [1:0] {
    LOAD,
    ROW,
    COL,
    DONE
  } wg_kt_state_t;

endpackage

// File: rtl/winograd_kt_row_xform.sv
// Combinational 1x3 -> 1x4 Winograd filter transform:
//   [a, b, c] -> [a, (a+b+c)>>>1, (a-b+c)>>>1, c]
// Sums are formed two bits wider than the inputs so they never overflow.
// The arithmetic shift rounds toward -inf. Each output is one bit wider than the inputs.
module winograd_kt_row_xform #(
  parameter int IN_WIDTH = 34
) (
  input  logic [IN_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0] b,
  input  logic [IN_WIDTH-1:0] c,
  output logic [IN_WIDTH:0]   y0,
  output logic [IN_WIDTH:0]   y1,
  output logic [IN_WIDTH:0]   y2,
  output logic [IN_WIDTH:0]   y3
);

  logic [IN_WIDTH+1:0] a_x, b_x, c_x;
  logic [IN_WIDTH+1:0] sum_p, sum_m;
  logic                unused_lsb;

  assign a_x   = {{2{a[IN_WIDTH-1]}}, a};
  assign b_x   = {{2{b[IN_WIDTH-1]}}, b};
  assign c_x   = {{2{c[IN_WIDTH-1]}}, c};
  assign sum_p = a_x + b_x + c_x;
  assign sum_m = a_x - b_x + c_x;

  // The bit shifted out by the halving is discarded.
  assign unused_lsb = sum_p[0] ^ sum_m[0];

  assign y0 = {a[IN_WIDTH-1], a};
  assign y1 = sum_p[IN_WIDTH+1:1];
  assign y2 = sum_m[IN_WIDTH+1:1];
  assign y3 = {c[IN_WIDTH-1], c};

endmodule

// File: rtl/winograd_kernel_transform.sv
// Sequential Winograd F(2x2,3x3) filter transform U = G*g*G^T.
// The block accepts the 9 words of a 3x3 filter in row-major order.
// It then transforms the filter columns (ROW phase, 3 cycles) and then the rows of T (COL phase, 4 cycles).
// The 4x4 result is held under valid/ready.
// Build option: define WINOGRAD_KT_SATURATE_EN to saturate the final narrowing
// to DATA_WIDTH instead of wrapping.
//
// state | meaning
// LOAD  | accepting filter elements g[0..8]
// ROW   | T[:,step] = G * g[:,step], step 0..2
// COL   | U[step,:] = T[step,:] * G^T, step 0..3, written to out_kernel
// DONE  | out_kernel valid, waiting for out_ready
module winograd_kernel_transform
  import winograd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_kernel [WG_TILE*WG_TILE],
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int XW = DATA_WIDTH + 2;
  // The fixed-point format does not affect the arithmetic; halving is a plain shift.
  localparam int unused_frac = FRAC_WIDTH;

  wg_kt_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] g_buf [WG_KSIZE][WG_KSIZE];
  logic [XW-1:0]         t_buf [WG_TILE][WG_KSIZE];
  logic [1:0]            ld_row, ld_col, step;
  logic                  last_elem;
  logic [XW-1:0]         x_a, x_b, x_c;
  logic [XW:0]           y [WG_TILE];
  logic [DATA_WIDTH-1:0] u_row [WG_TILE];

  assign last_elem = (ld_row == 2'd2) && (ld_col == 2'd2);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_elem) state_nxt = ROW;
      end
      ROW:  if (step == 2'd2) state_nxt = COL;
      COL:  if (step == 2'd3) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Feed the shared transform from a g column (sign-extended) or from a T row.
  always_comb begin
    x_a = '0;
    x_b = '0;
    x_c = '0;
    if (state == ROW) begin
      x_a = {{2{g_buf[0][step][DATA_WIDTH-1]}}, g_buf[0][step]};
      x_b = {{2{g_buf[1][step][DATA_WIDTH-1]}}, g_buf[1][step]};
      x_c = {{2{g_buf[2][step][DATA_WIDTH-1]}}, g_buf[2][step]};
    end else begin
      x_a = t_buf[step][0];
      x_b = t_buf[step][1];
      x_c = t_buf[step][2];
    end
  end

  winograd_kt_row_xform #(
    .IN_WIDTH(XW)
  ) u_xform (
    .a  (x_a),
    .b  (x_b),
    .c  (x_c),
    .y0 (y[0]),
    .y1 (y[1]),
    .y2 (y[2]),
    .y3 (y[3])
  );

  // Narrow transform results to the output word width.
  always_comb begin
    for (int k = 0; k < WG_TILE; k++) u_row[k] = '0;
`ifdef WINOGRAD_KT_SATURATE_EN
    for (int k = 0; k < WG_TILE; k++) begin
      if (y[k][XW:DATA_WIDTH-1] == {(XW-DATA_WIDTH+2){y[k][XW]}})
        u_row[k] = y[k][DATA_WIDTH-1:0];
      else if (y[k][XW])
        u_row[k] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
        u_row[k] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    for (int k = 0; k < WG_TILE; k++) u_row[k] = y[k][DATA_WIDTH-1:0];
`endif
  end

`ifndef WINOGRAD_KT_SATURATE_EN
  // When wrapping, the top bit of the wide result does not matter.
  logic unused_hi;
  assign unused_hi = y[0][XW] ^ y[1][XW] ^ y[2][XW] ^ y[3][XW];
`endif

  // Filter capture, T buffer, and output tile registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_row <= 2'd0;
      ld_col <= 2'd0;
      step   <= 2'd0;
      for (int r = 0; r < WG_KSIZE; r++)
        for (int c = 0; c < WG_KSIZE; c++) g_buf[r][c] <= '0;
      for (int r = 0; r < WG_TILE; r++)
        for (int c = 0; c < WG_KSIZE; c++) t_buf[r][c] <= '0;
      for (int i = 0; i < WG_TILE*WG_TILE; i++) out_kernel[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            g_buf[ld_row][ld_col] <= in_data;
            if (ld_col == 2'd2) begin
              ld_col <= 2'd0;
              ld_row <= (ld_row == 2'd2) ? 2'd0 : ld_row + 2'd1;
            end else begin
              ld_col <= ld_col + 2'd1;
            end
          end
        end
        ROW: begin
          // T holds values that fit in DATA_WIDTH+1 bits, so dropping the top bit is lossless.
          t_buf[0][step] <= y[0][XW-1:0];
          t_buf[1][step] <= y[1][XW-1:0];
          t_buf[2][step] <= y[2][XW-1:0];
          t_buf[3][step] <= y[3][XW-1:0];
          step <= (step == 2'd2) ? 2'd0 : step + 2'd1;
        end
        COL: begin
          out_kernel[{step, 2'd0}] <= u_row[0];
          out_kernel[{step, 2'd1}] <= u_row[1];
          out_kernel[{step, 2'd2}] <= u_row[2];
          out_kernel[{step, 2'd3}] <= u_row[3];
          step <= step + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_kernel_transform.sv
// Self-checking bench for winograd_kernel_transform.
// The reference model computes U = G*g*G^T with plain integer arithmetic.
// One compare process checks the DUT against that model on every cycle.
// Directed tiles with literal expected values pin the model.
module tb_winograd_kernel_transform;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_kernel [16];
  logic          out_valid;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int k_edge = 0;
  bit rnd_ready = 1'b0;
  bit prev_ov = 1'b0;

  logic [DW-1:0]      gq[$];
  logic [16*DW-1:0]   exp_q[$];
  logic [16*DW-1:0]   last_shown = '0;

  winograd_kernel_transform #(
    .DATA_WIDTH(DW),
    .FRAC_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_kernel (out_kernel),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint xf(input longint a, input longint b, input longint c, input int k);
    case (k)
      0:       return a;
      1:       return (a + b + c) >>> 1;
      2:       return (a - b + c) >>> 1;
      default: return c;
    endcase
  endfunction

  function automatic logic [DW-1:0] narrow(input longint v);
    logic [63:0] bits;
    bits = v;
`ifdef WINOGRAD_KT_SATURATE_EN
    if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
    return bits[DW-1:0];
  endfunction

  function automatic logic [16*DW-1:0] model_u(input logic [DW-1:0] gv [9]);
    longint g [3][3];
    longint t [4][3];
    logic [16*DW-1:0] u;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) g[r][c] = longint'($signed(gv[3*r+c]));
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) t[i][j] = xf(g[0][j], g[1][j], g[2][j], i);
    u = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) u[DW*(4*i+k) +: DW] = narrow(xf(t[i][0], t[i][1], t[i][2], k));
    return u;
  endfunction

  // Monitor: track accepted inputs and consumed outputs at each rising edge.
  always @(posedge clk) begin
    logic [DW-1:0] gv [9];
    cyc = cyc + 1;
    if (!rst_n) begin
      gq.delete();
      exp_q.delete();
      last_shown = '0;
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        last_shown = exp_q[0];
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        gq.push_back(in_data);
        if (gq.size() == 9) begin
          for (int i = 0; i < 9; i++) gv[i] = gq[i];
          exp_q.push_back(model_u(gv));
          gq.delete();
          k_edge = cyc;
        end
      end
    end
  end

  // Compare process: checks outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int bad;
    logic [16*DW-1:0] ref_u;
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        checks++;
        if (cyc - k_edge != 7) begin
          errors++;
          $display("FAIL latency: got %0d cycles, expected 7", cyc - k_edge);
        end
      end
      if (out_valid || in_ready) begin
        checks++;
        if (out_valid && exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_valid_unexpected: out_valid=1, expected no pending tile");
        end else begin
          ref_u = out_valid ? exp_q[0] : last_shown;
          bad = -1;
          for (int i = 0; i < 16; i++)
            if (bad < 0 && out_kernel[i] !== ref_u[DW*i +: DW]) bad = i;
          if (bad >= 0) begin
            errors++;
            $display("FAIL kernel_%s[%0d]: got %08h, expected %08h",
                     out_valid ? "valid" : "held", bad, out_kernel[bad], ref_u[DW*bad +: DW]);
          end
        end
      end
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_in_done: got %b, expected 0", in_ready);
        end
      end
    end
    prev_ov = out_valid && rst_n;
  end

  // Random consumer backpressure.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, got, expv);
    end
  endtask

  task automatic check_u(input string name, input logic [DW-1:0] e [16]);
    int bad;
    bad = -1;
    for (int i = 0; i < 16; i++) if (bad < 0 && out_kernel[i] !== e[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s[%0d]: got %08h, expected %08h", name, bad, out_kernel[bad], e[bad]);
    end
  endtask

  // Sends the first n elements of f; optional random idle gaps between elements.
  task automatic send(input logic [DW-1:0] f [9], input int n, input bit gaps);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = f[i];
      w = 0;
      while (!in_ready && w < 200) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0, expected 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int w;
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid got 0, expected 1 within 50 cycles", name);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] g2 [9], g3 [9], g6 [9], gr [9];
  logic [DW-1:0] e2 [16], e3 [16];

  initial begin
    int n;
    int w;
    int r;
    logic [DW-1:0] zeros [16];

    g2 = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
           32'h00020000, 32'h00020000, 32'h00020000,
           32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000};
    e2 = '{32'hFFFF0000, 32'hFFFE8000, 32'hFFFF8000, 32'hFFFF0000,
           32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
           32'hFFFE0000, 32'hFFFD0000, 32'hFFFF0000, 32'hFFFE0000,
           32'hFFFF0000, 32'hFFFE8000, 32'hFFFF8000, 32'hFFFF0000};
    g3 = '{0, 0, 0, 0, 32'h00010000, 0, 0, 0, 0};
    e3 = '{0, 0, 0, 0,
           0, 32'h00004000, 32'hFFFFC000, 0,
           0, 32'hFFFFC000, 32'h00004000, 0,
           0, 0, 0, 0};
    for (int i = 0; i < 9; i++) g6[i] = 32'h7FFF0000;
    for (int i = 0; i < 16; i++) zeros[i] = '0;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_u("reset_kernel", zeros);
    rst_n = 1'b1;

    // 2: basic tile, latency, and backpressure
    send(g2, 9, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t2_latency", n, 32'd7);
    check_u("t2_kernel", e2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_u("bp_kernel", e2);
    end
    accept();
    chk("acc_in_ready", {31'd0, in_ready}, 32'd1);
    chk("acc_out_valid", {31'd0, out_valid}, 32'd0);
    check_u("held_kernel", e2);

    // 3: single centre tap
    send(g3, 9, 1'b1);
    wait_out("t3");
    check_u("t3_kernel", e3);
    accept();

    // 5: reset in the middle of LOAD, then a full filter
    send(g3, 4, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_u("midreset_kernel", zeros);
    send(g2, 9, 1'b0);
    wait_out("t5");
    check_u("t5_kernel", e2);
    accept();

    // 6: large values exercise wrap/saturation
    send(g6, 9, 1'b0);
    wait_out("t6");
    chk("t6_u0", out_kernel[0], 32'h7FFF0000);
`ifdef WINOGRAD_KT_SATURATE_EN
    chk("t6_u5", out_kernel[5], 32'h7FFFFFFF);
`else
    chk("t6_u5", out_kernel[5], 32'h1FFDC000);
`endif
    accept();

    // random filters with random gaps and random backpressure
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 9; i++) begin
        r = $urandom_range(0, 3);
        if (r == 0)      gr[i] = $urandom();
        else if (r == 1) gr[i] = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF : 32'h80000000;
        else             gr[i] = 32'($signed($urandom_range(0, 32'h000FFFFF)) - 32'sh00080000);
      end
      send(gr, 9, 1'b1);
    end
    w = 0;
    while ((exp_q.size() > 0 || out_valid) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    checks++;
    if (exp_q.size() > 0 || out_valid) begin
      errors++;
      $display("FAIL drain: pending tiles %0d, expected 0", exp_q.size());
    end
    rnd_ready = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
